mem_arbiter: RTL and testbench

- Shares one single-ported 16-bit memory between the fetch stage (instruction reads) and the memory stage (data reads and writes).
- Serialises accesses and applies fixed data-side priority, with a starvation guard for fetch.
- Holds the memory busy for a fixed access latency, then returns a one-cycle ack plus read data to the granted requester.
- Sits between fetch/memory stages and the shared memory2c-style array.

---
 rtl/mem_arbiter.sv | 133 +++++++++++++
 tb/tb_mem_arbiter.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Arbiter that shares one single-ported 16-bit memory between instruction fetch and the data stage.
// Fixed data priority with a starvation guard that eventually forces a fetch grant.
module mem_arbiter #(
    parameter int unsigned LAT    = 2,
    parameter int unsigned STARVE = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        halt,
    input  logic        if_req,
    input  logic [15:0] if_addr,
    output logic        if_ack,
    output logic [15:0] if_rdata,
    input  logic        dm_req,
    input  logic        dm_wr,
    input  logic [15:0] dm_addr,
    input  logic [15:0] dm_wdata,
    output logic        dm_ack,
    output logic [15:0] dm_rdata,
    output logic        mem_en,
    output logic        mem_wr,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata,
    output logic        busy
);

    localparam int unsigned CW = 3;
    localparam int unsigned AW = 16;
    localparam int unsigned DW = 16;
    localparam int unsigned SW = (STARVE < 2) ? 1 : $clog2(STARVE + 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY_IF = 2'd1,
        BUSY_DM = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [SW-1:0]   starve_q, starve_d;
    logic            busy_d;
    logic            mem_en_d;
    logic            mem_wr_d;
    logic [AW-1:0]   mem_addr_d;
    logic [DW-1:0]   mem_wdata_d;

    logic            arb_point;
    logic            fetch_ok;
    logic            data_ok;
    logic            starve_hit;
    logic            grant_if;
    logic            grant_dm;

    // The ack cycle is the last BUSY cycle; read data passes straight through from the memory.
    assign if_ack   = (state_q == BUSY_IF) && (cnt_q == '0);
    assign dm_ack   = (state_q == BUSY_DM) && (cnt_q == '0);
    assign if_rdata = if_ack ? mem_rdata : '0;
    assign dm_rdata = (dm_ack && !mem_wr) ? mem_rdata : '0;

    // A requester being acked this cycle is not eligible, so the other side gets the slot with no bubble.
    assign arb_point  = (state_q == IDLE) || (cnt_q == '0);
    assign fetch_ok   = if_req && !halt && !if_ack;
    assign data_ok    = dm_req && !dm_ack;
    assign starve_hit = (starve_q >= SW'(STARVE));
    assign grant_if   = arb_point && fetch_ok && (starve_hit || !data_ok);
    assign grant_dm   = arb_point && data_ok && !grant_if;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        starve_d    = starve_q;
        busy_d      = busy;
        mem_en_d    = 1'b0;
        mem_wr_d    = mem_wr;
        mem_addr_d  = mem_addr;
        mem_wdata_d = mem_wdata;

        if (grant_if) begin
            state_d     = BUSY_IF;
            cnt_d       = CW'(LAT - 1);
            busy_d      = 1'b1;
            mem_en_d    = 1'b1;
            mem_wr_d    = 1'b0;
            mem_addr_d  = if_addr;
            mem_wdata_d = '0;
        end else if (grant_dm) begin
            state_d     = BUSY_DM;
            cnt_d       = CW'(LAT - 1);
            busy_d      = 1'b1;
            mem_en_d    = 1'b1;
            mem_wr_d    = dm_wr;
            mem_addr_d  = dm_addr;
            mem_wdata_d = dm_wdata;
        end else if (arb_point) begin
            state_d = IDLE;
            cnt_d   = '0;
            busy_d  = 1'b0;
        end else begin
            cnt_d = cnt_q - CW'(1);
        end

        // Starvation count only tracks data grants that bypass a waiting fetch.
        if (!if_req || grant_if) begin
            starve_d = '0;
        end else if (grant_dm && !starve_hit) begin
            starve_d = starve_q + SW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            starve_q  <= '0;
            busy      <= 1'b0;
            mem_en    <= 1'b0;
            mem_wr    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            starve_q  <= starve_d;
            busy      <= busy_d;
            mem_en    <= mem_en_d;
            mem_wr    <= mem_wr_d;
            mem_addr  <= mem_addr_d;
            mem_wdata <= mem_wdata_d;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: fetch, data priority, starvation guard, writes, halt and reset abort.
module tb_mem_arbiter;

    logic        clk;
    logic        rst;
    logic        halt;
    logic        if_req;
    logic [15:0] if_addr;
    logic        if_ack;
    logic [15:0] if_rdata;
    logic        dm_req;
    logic        dm_wr;
    logic [15:0] dm_addr;
    logic [15:0] dm_wdata;
    logic        dm_ack;
    logic [15:0] dm_rdata;
    logic        mem_en;
    logic        mem_wr;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic        busy;

    int checks;
    int failures;

    mem_arbiter #(.LAT(2), .STARVE(3)) dut (
        .clk       (clk),
        .rst       (rst),
        .halt      (halt),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_ack    (if_ack),
        .if_rdata  (if_rdata),
        .dm_req    (dm_req),
        .dm_wr     (dm_wr),
        .dm_addr   (dm_addr),
        .dm_wdata  (dm_wdata),
        .dm_ack    (dm_ack),
        .dm_rdata  (dm_rdata),
        .mem_en    (mem_en),
        .mem_wr    (mem_wr),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance past one rising edge; outputs are sampled 1ns after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        rst       = 1'b0;
        halt      = 1'b0;
        if_req    = 1'b0;
        if_addr   = '0;
        dm_req    = 1'b0;
        dm_wr     = 1'b0;
        dm_addr   = '0;
        dm_wdata  = '0;
        mem_rdata = '0;

        step();
        step();
        check("rst_busy",   32'(busy),     32'h0);
        check("rst_mem_en", 32'(mem_en),   32'h0);
        check("rst_addr",   32'(mem_addr), 32'h0);
        check("rst_if_ack", 32'(if_ack),   32'h0);
        check("rst_dm_ack", 32'(dm_ack),   32'h0);
        rst = 1'b1;

        // Single fetch
        if_req    = 1'b1;
        if_addr   = 16'h0010;
        mem_rdata = 16'h1234;
        step();
        check("f1_mem_en",  32'(mem_en),   32'h1);
        check("f1_addr",    32'(mem_addr), 32'h0010);
        check("f1_wr",      32'(mem_wr),   32'h0);
        check("f1_busy",    32'(busy),     32'h1);
        check("f1_ack_e",   32'(if_ack),   32'h0);
        step();
        check("f1_mem_en2", 32'(mem_en),   32'h0);
        check("f1_ack",     32'(if_ack),   32'h1);
        check("f1_rdata",   32'(if_rdata), 32'h1234);
        if_req = 1'b0;
        step();
        check("f1_idle",    32'(busy),     32'h0);
        check("f1_ack_off", 32'(if_ack),   32'h0);
        check("f1_rd_off",  32'(if_rdata), 32'h0);

        // Simultaneous requests: data first, fetch follows with no bubble
        if_req    = 1'b1;
        if_addr   = 16'h0020;
        dm_req    = 1'b1;
        dm_wr     = 1'b0;
        dm_addr   = 16'h0100;
        mem_rdata = 16'h5678;
        step();
        check("sim_dm_addr", 32'(mem_addr), 32'h0100);
        check("sim_dm_en",   32'(mem_en),   32'h1);
        step();
        check("sim_dm_ack",  32'(dm_ack),   32'h1);
        check("sim_dm_rd",   32'(dm_rdata), 32'h5678);
        check("sim_if_ack0", 32'(if_ack),   32'h0);
        dm_req = 1'b0;
        step();
        check("sim_if_addr", 32'(mem_addr), 32'h0020);
        check("sim_if_en",   32'(mem_en),   32'h1);
        check("sim_busy",    32'(busy),     32'h1);
        check("sim_dm_off",  32'(dm_ack),   32'h0);
        step();
        check("sim_if_ack",  32'(if_ack),   32'h1);
        check("sim_if_rd",   32'(if_rdata), 32'h5678);
        if_req = 1'b0;
        step();
        check("sim_idle",    32'(busy),     32'h0);

        // Starvation: three data grants while fetch waits (halted), then fetch beats data from IDLE
        halt      = 1'b1;
        if_req    = 1'b1;
        if_addr   = 16'h0030;
        dm_req    = 1'b1;
        dm_addr   = 16'h0300;
        mem_rdata = 16'h0abc;
        for (int g = 0; g < 3; g++) begin
            step();
            check($sformatf("stv_dm_grant%0d", g), 32'(mem_addr), 32'h0300);
            check($sformatf("stv_dm_en%0d", g),    32'(mem_en),   32'h1);
            step();
            check($sformatf("stv_dm_ack%0d", g),   32'(dm_ack),   32'h1);
            step();
            check($sformatf("stv_idle%0d", g),     32'(busy),     32'h0);
        end
        halt = 1'b0;
        step();
        check("stv_if_forced", 32'(mem_addr), 32'h0030);
        check("stv_if_en",     32'(mem_en),   32'h1);
        step();
        check("stv_if_ack",    32'(if_ack),   32'h1);
        if_req = 1'b0;
        step();
        check("stv_dm_after",  32'(mem_addr), 32'h0300);
        step();
        check("stv_dm_ack",    32'(dm_ack),   32'h1);
        dm_req = 1'b0;
        step();
        check("stv_idle",      32'(busy),     32'h0);

        // Write access
        dm_req    = 1'b1;
        dm_wr     = 1'b1;
        dm_addr   = 16'h0200;
        dm_wdata  = 16'hbeef;
        mem_rdata = 16'hffff;
        step();
        check("wr_en",     32'(mem_en),    32'h1);
        check("wr_wr",     32'(mem_wr),    32'h1);
        check("wr_wdata",  32'(mem_wdata), 32'hbeef);
        check("wr_addr",   32'(mem_addr),  32'h0200);
        step();
        check("wr_ack",    32'(dm_ack),    32'h1);
        check("wr_rdata",  32'(dm_rdata),  32'h0);
        check("wr_wr2",    32'(mem_wr),    32'h1);
        check("wr_wdata2", 32'(mem_wdata), 32'hbeef);
        dm_req = 1'b0;
        dm_wr  = 1'b0;
        step();
        check("wr_idle",   32'(busy),      32'h0);

        // halt blocks new fetch grants but not an in-flight one
        halt      = 1'b1;
        if_req    = 1'b1;
        if_addr   = 16'h0044;
        mem_rdata = 16'h7777;
        step();
        step();
        check("halt_busy",  32'(busy),   32'h0);
        check("halt_en",    32'(mem_en), 32'h0);
        halt = 1'b0;
        step();
        check("halt_grant", 32'(mem_en),   32'h1);
        check("halt_addr",  32'(mem_addr), 32'h0044);
        halt = 1'b1;
        step();
        check("halt_ack",   32'(if_ack),   32'h1);
        check("halt_rd",    32'(if_rdata), 32'h7777);
        if_req = 1'b0;
        halt   = 1'b0;
        step();
        check("halt_idle",  32'(busy),     32'h0);

        // Reset one cycle after a grant drops the access
        if_req    = 1'b1;
        if_addr   = 16'h0040;
        mem_rdata = 16'h4242;
        step();
        check("ra_grant",   32'(mem_en), 32'h1);
        rst = 1'b0;
        #1;
        check("ra_en",      32'(mem_en),   32'h0);
        check("ra_busy",    32'(busy),     32'h0);
        check("ra_ack",     32'(if_ack),   32'h0);
        check("ra_addr",    32'(mem_addr), 32'h0);
        step();
        check("ra_ack2",    32'(if_ack), 32'h0);
        rst = 1'b1;
        step();
        check("ra_regrant", 32'(mem_en),   32'h1);
        check("ra_readdr",  32'(mem_addr), 32'h0040);
        check("ra_noack",   32'(if_ack),   32'h0);
        step();
        check("ra_ack_lat", 32'(if_ack),   32'h1);
        check("ra_rdata",   32'(if_rdata), 32'h4242);
        if_req = 1'b0;
        step();
        check("ra_idle",    32'(busy),     32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
